// File: rtl/sb_param_cfg_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sb_param_cfg_chain_if : config-chain and routing-track bundle for the       |
// | parametrised switch block.                              Rev 1.0            |
// +----------------------------------------------------------------------------+
interface sb_param_cfg_chain_if #(
  parameter int CHAN_W = 9
);
  logic              ccff_head;
  logic              ccff_en;
  logic              cfg_commit;
  logic              cfg_rb;
  logic [CHAN_W-1:0] chany_bottom_in;
  logic [CHAN_W-1:0] chanx_left_in;
  logic [CHAN_W-1:0] bottom_grid_pin;
  logic [CHAN_W-1:0] left_grid_pin;
  logic [CHAN_W-1:0] chany_bottom_out;
  logic [CHAN_W-1:0] chanx_left_out;
  logic              ccff_tail;
  logic              cfg_full;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output ccff_head, ccff_en, cfg_commit, cfg_rb,
    output chany_bottom_in, chanx_left_in, bottom_grid_pin, left_grid_pin,
    input  chany_bottom_out, chanx_left_out,
    input  ccff_tail, cfg_full, cfg_done, cfg_err
  );

  modport slave (
    input  ccff_head, ccff_en, cfg_commit, cfg_rb,
    input  chany_bottom_in, chanx_left_in, bottom_grid_pin, left_grid_pin,
    output chany_bottom_out, chanx_left_out,
    output ccff_tail, cfg_full, cfg_done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/sb_param_cfg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sb_param_cfg_chain : switch block with a double-buffered serial config      |
// | chain. Optional macro SB_CFG_READBACK_EN adds active-frame readback.        |
// |                                                         Rev 1.0            |
// +----------------------------------------------------------------------------+
module sb_param_cfg_chain #(
  parameter int CHAN_W   = 9,
  parameter int MUX_SIZE = 2
) (
  input  wire logic           prog_clk,
  input  wire logic           pReset,
  sb_param_cfg_chain_if.slave bus
);
  localparam int NMUX    = 2 * CHAN_W;
  localparam int SEL_W   = (MUX_SIZE <= 2) ? 1 : $clog2(MUX_SIZE);
  localparam int CHAIN_L = NMUX * SEL_W;
  localparam int CNT_W   = $clog2(CHAIN_L + 1);
  localparam logic [CNT_W-1:0] c_L_CNT = CNT_W'(CHAIN_L);

  logic [CHAIN_L-1:0] r_shadow;
  logic [CHAIN_L-1:0] r_active;
  logic [CNT_W-1:0]   r_count;
  logic               r_done;
  logic               r_err;
  logic               w_full;

  assign w_full        = (r_count == c_L_CNT);
  assign bus.ccff_tail = r_shadow[CHAIN_L-1];
  assign bus.cfg_full  = w_full;
  assign bus.cfg_done  = r_done;
  assign bus.cfg_err   = r_err;

`ifndef SB_CFG_READBACK_EN
  logic w_unused_rb;
  assign w_unused_rb = bus.cfg_rb;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Shifting always wins; a concurrent commit is a protocol error.
      if (bus.ccff_en) begin
        r_shadow <= {r_shadow[CHAIN_L-2:0], bus.ccff_head};
        if (!w_full) r_count <= r_count + CNT_W'(1);
        if (bus.cfg_commit) r_err <= 1'b1;
      end else if (bus.cfg_commit) begin
        if (w_full) begin
          r_active <= r_shadow;
          r_count  <= '0;
          r_done   <= 1'b1;
          r_err    <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
`ifdef SB_CFG_READBACK_EN
      else if (bus.cfg_rb) begin
        r_shadow <= r_active;
        r_count  <= c_L_CNT;
      end
      if (bus.cfg_rb && (bus.ccff_en || bus.cfg_commit)) r_err <= 1'b1;
`endif
    end
  end

  // Bottom muxes: input k>=1 taps the left channel rotated forward by k.
  for (genvar i = 0; i < CHAN_W; i++) begin : g_bot
    logic [SEL_W-1:0]    w_sel;
    logic [MUX_SIZE-1:0] w_in;
    assign w_sel   = r_active[(NMUX-1-i)*SEL_W +: SEL_W];
    assign w_in[0] = bus.bottom_grid_pin[i];
    for (genvar k = 1; k < MUX_SIZE; k++) begin : g_in
      assign w_in[k] = bus.chanx_left_in[(i + k) % CHAN_W];
    end
    assign bus.chany_bottom_out[i] = (int'(w_sel) < MUX_SIZE) ? w_in[w_sel] : 1'b0;
  end

  // Left muxes: input k>=1 taps the bottom channel rotated backward by k.
  for (genvar j = 0; j < CHAN_W; j++) begin : g_left
    logic [SEL_W-1:0]    w_sel;
    logic [MUX_SIZE-1:0] w_in;
    assign w_sel   = r_active[(NMUX-1-(CHAN_W+j))*SEL_W +: SEL_W];
    assign w_in[0] = bus.left_grid_pin[j];
    for (genvar k = 1; k < MUX_SIZE; k++) begin : g_in
      assign w_in[k] = bus.chany_bottom_in[(j + CHAN_W*16 - k) % CHAN_W];
    end
    assign bus.chanx_left_out[j] = (int'(w_sel) < MUX_SIZE) ? w_in[w_sel] : 1'b0;
  end
endmodule
`default_nettype wire
